// File: rtl/lb_stencil_window.sv
// ---------------------------------------------------------------------------
// lb_stencil_window
// Pairs each current-row pixel with the previous-row pixel from the line
// buffer and builds a 2-row x KW-column sliding window. One registered window
// is produced per accepted pixel once the column warm-up is complete. The
// block tracks the row/column position inside a frame and flags misalignment.
//
// Parameters: DW pixel width, KW window width (2..8).
// Ports:
//   clk, reset (sync, active-high), clk_en (global enable), flush (sync clear)
//   img_width/img_height : frame geometry, latched on the first accept
//   in_data/in_valid     : current-row pixel stream
//   lb_data/lb_valid     : previous-row pixel from the line buffer
//   win_data/win_valid   : packed window {row1, row0}, column 0 oldest in LSBs
//   frame_done           : pulse after the last pixel of a frame
//   align_err, cfg_err   : sticky error flags
// Optional build macro: LB_STENCIL_ASSERT_EN adds a checker with embedded SVA
// and a window counter; port list and behaviour are unchanged.
// ---------------------------------------------------------------------------
module lb_stencil_window #(
  parameter int DW = 16,
  parameter int KW = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_en,
  input  logic                 flush,
  input  logic [15:0]          img_width,
  input  logic [15:0]          img_height,
  input  logic [DW-1:0]        in_data,
  input  logic                 in_valid,
  input  logic [DW-1:0]        lb_data,
  input  logic                 lb_valid,
  output logic [2*KW*DW-1:0]   win_data,
  output logic                 win_valid,
  output logic                 frame_done,
  output logic                 align_err,
  output logic                 cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ROW0   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [15:0] KW16  = 16'(KW);
  localparam logic [15:0] KW_M1 = 16'(KW - 1);

  state_t                  state_q, state_d;
  logic [15:0]             col_q, col_d;
  logic [15:0]             row_q, row_d;
  logic [15:0]             w_m1_q, w_m1_d;
  logic [15:0]             h_m1_q, h_m1_d;
  logic                    zero_q, zero_d;
  logic                    cfg_err_q, cfg_err_d;
  logic                    align_err_q, align_err_d;
  // Element KW-1 is the newest pixel, element 0 the oldest.
  logic [KW-1:0][DW-1:0]   row0_q, row0_d;
  logic [KW-1:0][DW-1:0]   row1_q, row1_d;
  logic [2*KW*DW-1:0]      win_data_q, win_data_d;
  logic                    win_valid_q, win_valid_d;
  logic                    frame_done_q, frame_done_d;
  logic                    accept_s;
  logic                    adv_s;
  logic                    align_viol_s;

  assign accept_s = clk_en & in_valid;

  // Any alignment violation seen on an enabled cycle.
  assign align_viol_s = clk_en & (
      (lb_valid & ~in_valid) |
      (in_valid & ~lb_valid & (state_q == S_STREAM)) |
      (lb_valid & (state_q == S_ROW0)) |
      (in_valid & (state_q == S_DONE)));

  // Next-state, counter, shift-register and output computation.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    w_m1_d       = w_m1_q;
    h_m1_d       = h_m1_q;
    zero_d       = zero_q;
    cfg_err_d    = cfg_err_q;
    align_err_d  = align_err_q | align_viol_s;
    row0_d       = row0_q;
    row1_d       = row1_q;
    win_data_d   = win_data_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    adv_s        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          // Geometry is latched on the same cycle as the first pixel.
          w_m1_d    = img_width - 16'd1;
          h_m1_d    = img_height - 16'd1;
          zero_d    = (img_width == 16'd0) || (img_height == 16'd0);
          cfg_err_d = cfg_err_q | (img_width < KW16) | (img_height < 16'd2);
          row1_d    = {in_data, row1_q[KW-1:1]};
          adv_s     = 1'b1;
        end else begin
          adv_s = 1'b0;
        end
      end
      S_ROW0, S_STREAM: begin
        if (accept_s) begin
          row1_d = {in_data, row1_q[KW-1:1]};
          adv_s  = 1'b1;
          // A missing line-buffer beat leaves row0 untouched (stale data).
          if ((state_q == S_STREAM) && lb_valid) begin
            row0_d = {lb_data, row0_q[KW-1:1]};
          end else begin
            row0_d = row0_q;
          end
        end else begin
          adv_s = 1'b0;
        end
      end
      S_DONE: begin
        frame_done_d = 1'b1;
        col_d        = 16'd0;
        row_d        = 16'd0;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (adv_s) begin
      if (zero_d) begin
        // Zero-sized frame: free-run the column counter until it wraps.
        col_d = col_q + 16'd1;
        if (col_q == 16'hFFFF) begin
          state_d = S_IDLE;
          row_d   = 16'd0;
        end else begin
          state_d = S_ROW0;
        end
      end else if (col_q == w_m1_d) begin
        col_d = 16'd0;
        row_d = row_q + 16'd1;
        if (row_q == h_m1_d) begin
          state_d = S_DONE;
        end else begin
          state_d = S_STREAM;
        end
      end else begin
        col_d = col_q + 16'd1;
        if (state_q == S_IDLE) begin
          state_d = S_ROW0;
        end else begin
          state_d = state_q;
        end
      end
      // Column gating keeps a window from straddling two rows.
      win_valid_d = (state_q == S_STREAM) && (col_q >= KW_M1) && !cfg_err_q;
      if (win_valid_d) begin
        win_data_d = {row1_d, row0_d};
      end else begin
        win_data_d = win_data_q;
      end
    end else begin
      win_valid_d = 1'b0;
    end
  end

  // State register; reset and flush clear everything, clk_en gates updates.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_q      <= S_IDLE;
      col_q        <= 16'd0;
      row_q        <= 16'd0;
      w_m1_q       <= 16'd0;
      h_m1_q       <= 16'd0;
      zero_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      align_err_q  <= 1'b0;
      row0_q       <= '0;
      row1_q       <= '0;
      win_data_q   <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else if (clk_en) begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      w_m1_q       <= w_m1_d;
      h_m1_q       <= h_m1_d;
      zero_q       <= zero_d;
      cfg_err_q    <= cfg_err_d;
      align_err_q  <= align_err_d;
      row0_q       <= row0_d;
      row1_q       <= row1_d;
      win_data_q   <= win_data_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign win_data   = win_data_q;
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
  assign align_err  = align_err_q;
  assign cfg_err    = cfg_err_q;

`ifdef LB_STENCIL_ASSERT_EN
  lb_stencil_window_chk #(.KW(KW)) u_chk (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .clk_en     (clk_en),
    .acc_win_i  (win_valid_d),
    .acc_row_i  (row_q),
    .w_m1_i     (w_m1_q),
    .h_m1_i     (h_m1_q),
    .win_valid  (win_valid_q),
    .frame_done (frame_done_q),
    .align_err  (align_err_q),
    .cfg_err    (cfg_err_q)
  );
`else
`endif

endmodule

`ifdef LB_STENCIL_ASSERT_EN
// Protocol checker: window count per frame and output invariants.
module lb_stencil_window_chk #(
  parameter int KW = 3
) (
  input logic        clk,
  input logic        reset,
  input logic        flush,
  input logic        clk_en,
  input logic        acc_win_i,
  input logic [15:0] acc_row_i,
  input logic [15:0] w_m1_i,
  input logic [15:0] h_m1_i,
  input logic        win_valid,
  input logic        frame_done,
  input logic        align_err,
  input logic        cfg_err
);
  logic [15:0] acc_row_q;
  logic [31:0] win_cnt_q;
  logic [31:0] win_exp_s;

  assign win_exp_s = 32'(h_m1_i) * (32'(w_m1_i) - 32'(KW) + 32'd2);

  // Row of the accept behind the current window, and windows in this frame.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      acc_row_q <= 16'd0;
      win_cnt_q <= 32'd0;
    end else if (clk_en) begin
      if (acc_win_i) acc_row_q <= acc_row_i;
      if (frame_done)     win_cnt_q <= 32'd0;
      else if (win_valid) win_cnt_q <= win_cnt_q + 32'd1;
    end
  end

  a_win_row: assert property (@(posedge clk) disable iff (reset || flush)
    win_valid |-> (acc_row_q >= 16'd1));
  a_win_cnt: assert property (@(posedge clk) disable iff (reset || flush)
    (frame_done && clk_en && !cfg_err) |-> (win_cnt_q == win_exp_s));
  a_excl: assert property (@(posedge clk) disable iff (reset || flush)
    !(win_valid && frame_done));
  a_sticky: assert property (@(posedge clk)
    ($past(align_err) && !align_err) |-> $past(reset || flush));
endmodule
`endif
